// File: rtl/calc_percent_div.sv
// -----------------------------------------------------------------------------
// calc_percent_div
//
// Purpose:
//   Unsigned DATA_W-bit divider for the percentage path. The upstream
//   calculate stage hands over a*100 as the dividend; this block returns the
//   quotient and remainder using a restoring radix-2 divider, one quotient
//   bit per cycle, MSB first.
//
// Configuration:
//   CALC_DIV_ROUND_EN  when defined, a nonzero-divisor result is rounded half
//                      up (quotient+1 when 2*remainder >= divisor). The
//                      remainder output is always the true remainder.
//                      When undefined, the quotient is truncated.
//
// Ports:
//   ap_clk     in   sole clock, rising edge
//   ap_rst     in   synchronous active-high reset
//   ap_start   in   request to accept operands (looked at only in IDLE)
//   ap_done    out  one-cycle pulse, results valid (the DONE cycle)
//   ap_idle    out  high while in IDLE
//   ap_ready   out  one-cycle pulse, operands consumed this cycle
//   dividend   in   DATA_W unsigned dividend (a*100)
//   divisor    in   DATA_W unsigned divisor
//   ap_return  out  registered quotient (all ones when divisor was 0)
//   remainder  out  registered remainder (dividend when divisor was 0)
//   div_zero   out  registered flag, last operation had divisor 0
//   dbg_state  out  current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: operands transfer in the IDLE cycle where ap_start=1; ap_ready
// is high in exactly that cycle (combinational from ap_start, masked while
// ap_rst is asserted). ap_start is ignored in every other state. Results
// are valid during the single ap_done cycle and hold until the next one.
// -----------------------------------------------------------------------------
module calc_percent_div #(
    parameter int DATA_W = 32
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] ap_return,
    output logic [DATA_W-1:0] remainder,
    output logic              div_zero,
    output logic [1:0]        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] quot_q, quot_d;     // dividend bits shifted out, quotient bits shifted in
    logic [DATA_W-1:0] part_q, part_d;     // partial remainder
    logic [DATA_W-1:0] dvsr_q, dvsr_d;     // latched divisor
    logic [CNT_W-1:0]  cnt_q, cnt_d;       // step index 0..DATA_W-1
    logic [DATA_W-1:0] ret_q, ret_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic              dz_q, dz_d;

    // One restoring step: bring down the next dividend bit and subtract the
    // divisor if it fits. The shifted value is DATA_W+1 bits wide, but when
    // the subtraction happens the true difference is below the divisor, so
    // a DATA_W-bit wrap-around subtraction yields the exact result.
    logic [DATA_W:0]   shifted;
    logic              fits;
    logic [DATA_W-1:0] step_rem;
    logic [DATA_W-1:0] step_quot;
    logic [DATA_W-1:0] final_quot;

    always_comb begin
        shifted   = {part_q, quot_q[DATA_W-1]};
        fits      = (shifted >= {1'b0, dvsr_q});
        step_rem  = fits ? (shifted[DATA_W-1:0] - dvsr_q) : shifted[DATA_W-1:0];
        step_quot = {quot_q[DATA_W-2:0], fits};
`ifdef CALC_DIV_ROUND_EN
        // Round half up. The quotient cannot overflow here: rounding needs
        // divisor >= 2, which caps the quotient well below all ones.
        final_quot = step_quot + DATA_W'({step_rem, 1'b0} >= {1'b0, dvsr_q});
`else
        final_quot = step_quot;
`endif
    end

    always_comb begin
        state_d  = state_q;
        quot_d   = quot_q;
        part_d   = part_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        ret_d    = ret_q;
        rem_d    = rem_q;
        dz_d     = dz_q;
        ap_idle  = 1'b0;
        ap_ready = 1'b0;
        ap_done  = 1'b0;

        case (state_q)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start && !ap_rst) begin
                    ap_ready = 1'b1;
                    quot_d   = dividend;
                    dvsr_d   = divisor;
                    part_d   = '0;
                    cnt_d    = '0;
                    if (divisor == '0) begin
                        // Nothing to iterate: publish the fixed result now.
                        state_d = DONE;
                        ret_d   = '1;
                        rem_d   = dividend;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                quot_d = step_quot;
                part_d = step_rem;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    // The last step's result goes straight to the outputs so
                    // they are valid during the DONE cycle.
                    state_d = DONE;
                    ret_d   = final_quot;
                    rem_d   = step_rem;
                    dz_d    = 1'b0;
                end
            end
            DONE: begin
                ap_done = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= IDLE;
            quot_q  <= '0;
            part_q  <= '0;
            dvsr_q  <= '0;
            cnt_q   <= '0;
            ret_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            quot_q  <= quot_d;
            part_q  <= part_d;
            dvsr_q  <= dvsr_d;
            cnt_q   <= cnt_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    assign ap_return = ret_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign dbg_state = state_q;

endmodule
